// File: rtl/pipeline_hazard_controller.sv
// Hazard/sequencing control for a 5-stage pipeline without forwarding.
// Scoreboards in-flight register writes, stalls ID on RAW, and freezes fetch behind control transfers.

module hazardSbCell #(
  parameter int CNT_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                dec,
  output logic [CNT_BITS-1:0] cnt
);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  // Simultaneous inc/dec cancel; out-of-range requests saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset)                                cnt <= '0;
    else if (inc && !dec && cnt != CNT_MAX)   cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0)        cnt <= cnt - 1'b1;
  end
endmodule

module pipeline_hazard_controller #(
  parameter int NREGS     = 32,
  parameter int CNT_BITS  = 2,
  parameter int PERF_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 id_RegWrite,
  input  logic [4:0]           id_WriteRegister,
  input  logic                 id_is_ctrl,
  input  logic                 wb_RegWrite,
  input  logic [4:0]           wb_WriteRegister,
  input  logic                 wb_ctrl_done,
  output logic                 pc_write,
  output logic                 pc_sel_wb,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic [PERF_BITS-1:0] stall_cycles
);
  typedef enum logic {RUN, CTRL_WAIT} state_t;

  localparam logic [PERF_BITS-1:0] STALL_MAX = '1;

  state_t                         state, stateNxt;
  logic [NREGS-1:0][CNT_BITS-1:0] pend;
  logic [NREGS-1:0]               incVec, decVec;
  logic                           rsHit, rtHit, raw, issue;

  assign rsHit = id_uses_rs && (id_rs != '0) && (pend[id_rs] != '0);
  assign rtHit = id_uses_rt && (id_rt != '0) && (pend[id_rt] != '0);
  assign raw   = id_valid && (rsHit || rtHit);
  assign issue = !reset && (state == RUN) && id_valid && !raw;

  // Register 0 is hardwired: its cell never sees inc/dec so it stays at zero.
  for (genvar g = 0; g < NREGS; g++) begin : gSb
    if (g == 0) begin : gZero
      assign incVec[g] = 1'b0;
      assign decVec[g] = 1'b0;
    end else begin : gReg
      assign incVec[g] = issue && id_RegWrite && (id_WriteRegister == 5'(g));
      assign decVec[g] = wb_RegWrite && (wb_WriteRegister == 5'(g));
    end

    hazardSbCell #(.CNT_BITS(CNT_BITS)) uCell (
      .clk   (clk),
      .reset (reset),
      .inc   (incVec[g]),
      .dec   (decVec[g]),
      .cnt   (pend[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt     = state;
    pc_write     = 1'b0;
    pc_sel_wb    = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      stateNxt     = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (!id_valid) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (raw) begin
            id_ex_bubble = 1'b1;
          end else if (id_is_ctrl) begin
            // Control goes down the pipe; the wrong-path fetch behind it is squashed.
            if_id_flush = 1'b1;
            stateNxt    = CTRL_WAIT;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        CTRL_WAIT: begin
          id_ex_bubble = 1'b1;
          if (wb_ctrl_done) begin
            pc_write    = 1'b1;
            pc_sel_wb   = 1'b1;
            if_id_flush = 1'b1;
            stateNxt    = RUN;
          end
        end
        default: stateNxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                      stall_cycles <= '0;
    else if (id_ex_bubble && stall_cycles != STALL_MAX) stall_cycles <= stall_cycles + 1'b1;
  end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scenarios plus randomized traffic against a per-register pending-count model.
module tb_pipeline_hazard_controller;
  localparam int NREGS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_uses_rs, id_uses_rt, id_RegWrite, id_is_ctrl;
  logic [4:0]  id_rs, id_rt, id_WriteRegister, wb_WriteRegister;
  logic        wb_RegWrite, wb_ctrl_done;
  logic        pc_write, pc_sel_wb, if_id_write, if_id_flush, id_ex_bubble;
  logic [15:0] stall_cycles;
  logic [4:0]  ctl;

  int errors = 0;
  int checks = 0;

  int mdlPend[NREGS];
  bit mdlCtrl;
  int mdlStall;

  always #5 clk = ~clk;

  assign ctl = {pc_write, pc_sel_wb, if_id_write, if_id_flush, id_ex_bubble};

  pipeline_hazard_controller #(.NREGS(NREGS), .CNT_BITS(2), .PERF_BITS(16)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_RegWrite(id_RegWrite), .id_WriteRegister(id_WriteRegister), .id_is_ctrl(id_is_ctrl),
    .wb_RegWrite(wb_RegWrite), .wb_WriteRegister(wb_WriteRegister), .wb_ctrl_done(wb_ctrl_done),
    .pc_write(pc_write), .pc_sel_wb(pc_sel_wb), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .stall_cycles(stall_cycles)
  );

  function automatic bit mdlRaw();
    if (!id_valid) return 1'b0;
    if (id_uses_rs && id_rs != 5'd0 && mdlPend[id_rs] > 0) return 1'b1;
    if (id_uses_rt && id_rt != 5'd0 && mdlPend[id_rt] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // {pc_write, pc_sel_wb, if_id_write, if_id_flush, id_ex_bubble}
  function automatic logic [4:0] mdlExpect();
    if (reset)     return 5'b00011;
    if (mdlCtrl)   return wb_ctrl_done ? 5'b11011 : 5'b00001;
    if (!id_valid) return 5'b10101;
    if (mdlRaw())  return 5'b00001;
    if (id_is_ctrl) return 5'b00010;
    return 5'b10100;
  endfunction

  task automatic tick();
    logic [4:0] e;
    bit issue;
    int d;
    @(posedge clk);
    e     = mdlExpect();
    issue = !reset && !mdlCtrl && id_valid && !mdlRaw();
    if (reset) begin
      foreach (mdlPend[r]) mdlPend[r] = 0;
      mdlCtrl  = 1'b0;
      mdlStall = 0;
    end else begin
      if (e[0] && mdlStall < 65535) mdlStall++;
      if (issue && id_is_ctrl) mdlCtrl = 1'b1;
      else if (mdlCtrl && wb_ctrl_done) mdlCtrl = 1'b0;
      for (int r = 1; r < NREGS; r++) begin
        d = ((issue && id_RegWrite && int'(id_WriteRegister) == r) ? 1 : 0)
          - ((wb_RegWrite && int'(wb_WriteRegister) == r) ? 1 : 0);
        mdlPend[r] = mdlPend[r] + d;
        if (mdlPend[r] > 3) mdlPend[r] = 3;
        if (mdlPend[r] < 0) mdlPend[r] = 0;
      end
    end
    #1;
  endtask

  task automatic setId(input bit v, input int rs, input int rt, input bit uRs, input bit uRt,
                       input bit rw, input int wr, input bit isCtrl);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = uRs; id_uses_rt = uRt;
    id_RegWrite = rw; id_WriteRegister = 5'(wr); id_is_ctrl = isCtrl;
  endtask

  task automatic setWb(input bit rw, input int wr, input bit done);
    wb_RegWrite = rw; wb_WriteRegister = 5'(wr); wb_ctrl_done = done;
  endtask

  task automatic idle();
    setId(0, 0, 0, 0, 0, 0, 0, 0);
    setWb(0, 0, 0);
  endtask

  task automatic doReset();
    reset = 1'b1; idle(); tick(); tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b1; idle(); tick(); tick();
    checks++; if (ctl !== 5'b00011) begin errors++; $display("FAIL reset_ctl: got %b want 00011", ctl); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    ok = 1'b1;
    for (int r = 0; r < NREGS; r++) if (dut.pend[r] !== 2'd0) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL reset_pend: got nonzero want all 0"); end
    reset = 1'b0; #1;
    checks++; if (ctl !== 5'b10101) begin errors++; $display("FAIL reset_release: got %b want 10101", ctl); end
  endtask

  task automatic test_raw();
    doReset();
    setId(1, 1, 0, 1, 0, 1, 8, 0); #1;
    checks++; if (ctl !== 5'b10100) begin errors++; $display("FAIL raw_addi_issue: got %b want 10100", ctl); end
    tick();
    setId(1, 8, 8, 1, 1, 1, 9, 0);
    for (int c = 0; c < 3; c++) begin
      setWb(c == 2, 8, 0); #1;
      checks++; if (ctl !== 5'b00001) begin errors++; $display("FAIL raw_stall%0d: got %b want 00001", c, ctl); end
      tick();
    end
    setWb(0, 0, 0); #1;
    checks++; if (ctl !== 5'b10100) begin errors++; $display("FAIL raw_add_issue: got %b want 10100", ctl); end
    checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL raw_stall_cnt: got %0d want 3", stall_cycles); end
    tick(); idle();
  endtask

  task automatic test_reg0_indep();
    doReset();
    setId(1, 0, 0, 1, 0, 1, 0, 0); #1;
    checks++; if (ctl !== 5'b10100) begin errors++; $display("FAIL r0_addi: got %b want 10100", ctl); end
    tick();
    setId(1, 0, 0, 1, 1, 1, 2, 0); #1;
    checks++; if (ctl !== 5'b10100) begin errors++; $display("FAIL r0_use: got %b want 10100", ctl); end
    checks++; if (dut.pend[0] !== 2'd0) begin errors++; $display("FAIL r0_pend: got %0d want 0", dut.pend[0]); end
    tick();
    setId(1, 3, 0, 1, 0, 1, 8, 0); #1;
    checks++; if (ctl !== 5'b10100) begin errors++; $display("FAIL indep_addi: got %b want 10100", ctl); end
    tick();
    setId(1, 11, 12, 1, 1, 1, 10, 0); #1;
    checks++; if (ctl !== 5'b10100) begin errors++; $display("FAIL indep_or: got %b want 10100", ctl); end
    tick(); idle(); #1;
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL indep_stall: got %0d want 0", stall_cycles); end
  endtask

  task automatic test_branch();
    doReset();
    setId(1, 1, 2, 1, 1, 0, 0, 1); #1;
    checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL br_issue: got %b want 00010", ctl); end
    tick(); idle();
    for (int c = 0; c < 3; c++) begin
      setWb(0, 0, c == 2); #1;
      checks++;
      if (ctl !== ((c == 2) ? 5'b11011 : 5'b00001)) begin
        errors++; $display("FAIL br_wait%0d: got %b want %b", c, ctl, (c == 2) ? 5'b11011 : 5'b00001);
      end
      tick();
    end
    setWb(0, 0, 0); #1;
    checks++; if (ctl !== 5'b10101) begin errors++; $display("FAIL br_refetch: got %b want 10101", ctl); end
    checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL br_stall_cnt: got %0d want 3", stall_cycles); end
  endtask

  task automatic test_raw_ctrl();
    doReset();
    setId(1, 1, 0, 1, 0, 1, 8, 0); tick();
    setId(1, 8, 0, 1, 0, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      setWb(c == 2, 8, 0); #1;
      checks++; if (ctl !== 5'b00001) begin errors++; $display("FAIL jr_hold%0d: got %b want 00001", c, ctl); end
      tick();
    end
    setWb(0, 0, 0); #1;
    checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL jr_issue: got %b want 00010", ctl); end
    tick(); idle();
    for (int c = 0; c < 3; c++) begin setWb(0, 0, c == 2); tick(); end
    setWb(0, 0, 0);
    setId(1, 0, 0, 0, 0, 1, 31, 1); #1;
    checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL jal_issue: got %b want 00010", ctl); end
    tick(); idle();
    checks++; if (dut.pend[31] !== 2'd1) begin errors++; $display("FAIL jal_pend: got %0d want 1", dut.pend[31]); end
    for (int c = 0; c < 3; c++) begin setWb(c == 2, 31, c == 2); tick(); end
    setWb(0, 0, 0); #1;
    checks++; if (dut.pend[31] !== 2'd0) begin errors++; $display("FAIL jal_clear: got %0d want 0", dut.pend[31]); end
    checks++; if (ctl !== 5'b10101) begin errors++; $display("FAIL jal_run: got %b want 10101", ctl); end
  endtask

  task automatic test_overlap();
    doReset();
    for (int c = 0; c < 3; c++) begin
      setId(1, 0, 0, 0, 0, 1, 5, 0); #1;
      checks++; if (ctl !== 5'b10100) begin errors++; $display("FAIL ovl_issue%0d: got %b want 10100", c, ctl); end
      tick();
    end
    checks++; if (dut.pend[5] !== 2'd3) begin errors++; $display("FAIL ovl_three: got %0d want 3", dut.pend[5]); end
    setWb(1, 5, 0); tick(); setWb(0, 0, 0);
    checks++; if (dut.pend[5] !== 2'd3) begin errors++; $display("FAIL ovl_same_cycle: got %0d want 3", dut.pend[5]); end
    tick();
    checks++; if (dut.pend[5] !== 2'd3) begin errors++; $display("FAIL ovl_sat_hi: got %0d want 3", dut.pend[5]); end
    idle(); setWb(1, 6, 0); tick(); setWb(0, 0, 0);
    checks++; if (dut.pend[6] !== 2'd0) begin errors++; $display("FAIL ovl_sat_lo: got %0d want 0", dut.pend[6]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    doReset();
    setId(1, 0, 0, 0, 0, 1, 7, 0); tick(); tick();
    setId(1, 1, 0, 1, 0, 0, 0, 1); tick(); idle(); #1;
    checks++; if (ctl !== 5'b00001) begin errors++; $display("FAIL mid_wait: got %b want 00001", ctl); end
    checks++; if (dut.pend[7] !== 2'd2) begin errors++; $display("FAIL mid_pend7: got %0d want 2", dut.pend[7]); end
    tick();
    reset = 1'b1; #1;
    checks++; if (ctl !== 5'b00011) begin errors++; $display("FAIL mid_reset_ctl: got %b want 00011", ctl); end
    tick(); reset = 1'b0; #1;
    checks++; if (ctl !== 5'b10101) begin errors++; $display("FAIL mid_run: got %b want 10101", ctl); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL mid_stall: got %0d want 0", stall_cycles); end
    ok = 1'b1;
    for (int r = 0; r < NREGS; r++) if (dut.pend[r] !== 2'd0) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL mid_pend: got nonzero want all 0"); end
  endtask

  task automatic test_random();
    int wr, wbr;
    bit ok;
    doReset();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      wr  = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 7));
      wbr = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 7));
      setId($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            wr, $urandom_range(0, 5) == 0);
      setWb(mdlPend[wbr] > 0 && $urandom_range(0, 1) == 1, wbr,
            mdlCtrl ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0));
      if (mdlPend[wr] >= 3 && !(wb_RegWrite && wbr == wr)) id_RegWrite = 1'b0;
      #1;
      checks++; if (ctl !== mdlExpect()) begin errors++; $display("FAIL rnd_ctl@%0d: got %b want %b", n, ctl, mdlExpect()); end
      checks++; if (stall_cycles !== 16'(mdlStall)) begin errors++; $display("FAIL rnd_stall@%0d: got %0d want %0d", n, stall_cycles, mdlStall); end
      ok = 1'b1;
      for (int r = 0; r < NREGS; r++) if (dut.pend[r] !== 2'(mdlPend[r])) ok = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL rnd_pend@%0d: scoreboard differs from model", n); end
      tick();
    end
    reset = 1'b0; idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_raw();
    test_reg0_indep();
    test_branch();
    test_raw_ctrl();
    test_overlap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequencing controller for the 5-stage IF/ID/EX/MEM/WB pipeline. The pipeline has no forwarding, and the PC redirect resolves only in WB.
- Keeps a per-register scoreboard of in-flight writes and stalls ID on RAW hazards.
- Freezes fetch while a branch, jump, jr or jal is in flight, and squashes the wrong-path instruction.
- Drives the enable, bubble and flush controls of the PC, IF_ID and ID_EX pipeline registers. Exposes a saturating stall counter.

Parameters:
- NREGS, 32, number of architectural registers tracked.
- CNT_BITS, 2, width of each scoreboard pending counter. Holds at most 3 in-flight writers (EX, MEM, WB).
- PERF_BITS, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  IF_ID holds a real (non-squashed) instruction.
- id_rs  in  5  rs field of the ID instruction.
- id_rt  in  5  rt field of the ID instruction.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_RegWrite  in  1  ID instruction writes the register file.
- id_WriteRegister  in  5  destination of the ID instruction.
- id_is_ctrl  in  1  ID instruction is beq, bne, j, jal or jr.
- wb_RegWrite  in  1  WB stage commits a register write this cycle.
- wb_WriteRegister  in  5  WB destination.
- wb_ctrl_done  in  1  control instruction is in WB; NewPC is valid this cycle.
- pc_write  out  1  PC register load enable.
- pc_sel_wb  out  1  1 = PC loads NewPC from WB; 0 = PC+4.
- if_id_write  out  1  IF_ID load enable.
- if_id_flush  out  1  clear IF_ID to NOP / id_valid=0.
- id_ex_bubble  out  1  load NOP (all control bits 0) into ID_EX instead of the ID outputs.
- stall_cycles  out  PERF_BITS  saturating count of cycles with id_ex_bubble=1 after reset.

Behaviour:
- Reset (sync, active-high, cycle asserted):
  - State goes to RUN; all scoreboard counters and stall_cycles go to 0.
  - Outputs while reset=1: pc_write=0, pc_sel_wb=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1.
  - Reset mid-operation discards any pending redirect and all pending counts.
- Hazard check (combinational):
  - raw = id_valid and ((id_uses_rs and id_rs!=0 and pend[id_rs]!=0) or (id_uses_rt and id_rt!=0 and pend[id_rt]!=0)).
  - Register 0 is never pending.
- Issue:
  - issue = (state==RUN) and id_valid and not raw.
  - On issue with id_RegWrite and id_WriteRegister!=0: pend[id_WriteRegister] increments.
- Commit:
  - wb_RegWrite and wb_WriteRegister!=0: pend[wb_WriteRegister] decrements.
  - The register file writes at the same edge, so the hazard clears the cycle after WB. Decode latency from WB of the producer is 1 cycle.
  - Same-cycle increment and decrement on one register: the count is unchanged.
- Counter limits:
  - Increment at max or decrement at 0 is a protocol error.
  - Counters saturate and never wrap; the bench asserts on it.
- FSM, RUN:
  - raw=1: pc_write=0, if_id_write=0, id_ex_bubble=1, stay in RUN.
  - issue with id_is_ctrl=1: ID_EX loads the control instruction (id_ex_bubble=0), pc_write=0, if_id_flush=1 to squash the wrong-path fetch. Next state CTRL_WAIT.
  - issue otherwise: pc_write=1, if_id_write=1, id_ex_bubble=0.
  - id_valid=0: pc_write=1, if_id_write=1, id_ex_bubble=1.
- FSM, CTRL_WAIT:
  - pc_write=0, if_id_write=0, id_ex_bubble=1.
  - On wb_ctrl_done: pc_write=1, pc_sel_wb=1, if_id_flush=1, next state RUN.
  - Minimum penalty for a control instruction is 3 bubble cycles (EX, MEM, WB) plus 1 refetch cycle.
- Priority: raw takes precedence over id_is_ctrl. A beq or jr waits for its operands before entering CTRL_WAIT.
- jal: RegWrite is scoreboarded at issue like any writer.
- wb_ctrl_done in RUN is a protocol error and is ignored.
- stall_cycles: increments on every cycle with id_ex_bubble=1 and reset=0. Saturates at 2^PERF_BITS-1.
- Outputs are combinational from the state, the scoreboard and the inputs. Scoreboard and state are registered.

Test Plan:
- RAW stall: reset, then issue addi $8 (RegWrite, dest 8), then next ID add $9,$8,$8 -> 3 cycles with id_ex_bubble=1 and pc_write=0. The add issues the cycle after wb_RegWrite with wb_WriteRegister=8. stall_cycles=3.
- Register 0 and independent registers: addi $0 followed by add using $0, and addi $8 followed by or $10,$11,$12 -> zero stalls, pend[0] stays 0.
- Branch redirect: issue beq with operands clear -> cycle 1 if_id_flush=1, pc_write=0. CTRL_WAIT for 3 cycles of bubbles. wb_ctrl_done -> pc_write=1, pc_sel_wb=1, then RUN.
- RAW plus control: addi $8 then jr $8 -> jr held by raw until $8 commits, then enters CTRL_WAIT. jal issue sets pend[31]=1, and it clears on its WB.
- Overlapping writers and same-cycle events: three back-to-back writes to $5 -> pend[5]=3. Issue of a 4th writer in the same cycle as a WB commit of $5 -> stays 3, no error.
- Reset mid-CTRL_WAIT with pend[7]=2 -> next cycle state RUN, all pend=0, stall_cycles=0. While reset=1: if_id_flush=1 and id_ex_bubble=1.
